// File: rtl/aes_top.sv
// -----------------------------------------------------------------------------
// aes_top : iterative AES-128 encryption core (FIPS-197, encrypt only).
//   One round per clock with an on-the-fly key schedule. A block is captured
//   in IDLE, ten rounds run in BUSY, and the ciphertext is presented with a
//   one-cycle valid pulse. The capture-to-valid latency is 10 cycles, and a
//   new block can start every 11 cycles.
//   Optional feature macro: AES_COMPLEMENTARY_OUT_EN adds a registered
//   bitwise-inverted copy of the ciphertext and a matching valid strobe.
//   AES_rst_n is a synchronous reset that is active HIGH, despite its name.
// -----------------------------------------------------------------------------
module aes_top (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
`ifdef AES_COMPLEMENTARY_OUT_EN
    ,
    output logic [127:0] AES_data_out_complementary,
    output logic         AES_data_out_complementary_valid
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_e;

    // FIPS-197 S-box. Entry 0 is held in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ---------------------------------------------------------------- helpers
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] blk);
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            res[8*i +: 8] = sbox(blk[8*i +: 8]);
        end
        return res;
    endfunction

    // Byte 4c+r sits at row r, column c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] blk);
        logic [127:0] res;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(4*c+r) -: 8] = blk[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] blk);
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = blk[127-32*c -: 8];
            a1 = blk[119-32*c -: 8];
            a2 = blk[111-32*c -: 8];
            a3 = blk[103-32*c -: 8];
            res[127-32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        return res;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Derives the next round key from the current one.
    function automatic logic [127:0] next_round_key(input logic [127:0] k,
                                                    input logic [7:0]   rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // ---------------------------------------------------------------- state
    fsm_e         fsm_q,      fsm_d;
    logic [3:0]   round_q,    round_d;
    logic [127:0] state_q,    state_d;
    logic [127:0] key_q,      key_d;
    logic [127:0] data_out_q, data_out_d;
    logic         valid_q,    valid_d;

    logic [127:0] round_key_s;
    logic [127:0] shifted_s;
    logic [127:0] round_out_s;

    // One AES round on the held state, using the key for the current round.
    always_comb begin
        round_key_s = next_round_key(key_q, rcon(round_q));
        shifted_s   = shift_rows(sub_bytes(state_q));
        if (round_q == 4'd10) begin
            round_out_s = shifted_s ^ round_key_s;
        end else begin
            round_out_s = mix_columns(shifted_s) ^ round_key_s;
        end
    end

    // Next-state logic: capture in IDLE, iterate rounds in BUSY, publish at the end.
    always_comb begin
        fsm_d      = fsm_q;
        round_d    = round_q;
        state_d    = state_q;
        key_d      = key_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (AES_en) begin
                    state_d = AES_data_in ^ AES_key_in;
                    key_d   = AES_key_in;
                    round_d = 4'd1;
                    fsm_d   = BUSY;
                end else begin
                    round_d = 4'd0;
                end
            end
            BUSY: begin
                state_d = round_out_s;
                key_d   = round_key_s;
                if (round_q == 4'd10) begin
                    data_out_d = round_out_s;
                    valid_d    = 1'b1;
                    round_d    = 4'd0;
                    fsm_d      = IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                fsm_d   = IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge AES_clk) begin
        if (AES_rst_n) begin
            fsm_q      <= IDLE;
            round_q    <= 4'd0;
            state_q    <= 128'd0;
            key_q      <= 128'd0;
            data_out_q <= 128'd0;
            valid_q    <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            round_q    <= round_d;
            state_q    <= state_d;
            key_q      <= key_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign AES_data_out       = data_out_q;
    assign AES_data_out_valid = valid_q;

`ifdef AES_COMPLEMENTARY_OUT_EN
    logic [127:0] comp_q;
    logic         comp_valid_q;

    // Inverted ciphertext copy, updated on the same edge as the main output.
    always_ff @(posedge AES_clk) begin
        if (AES_rst_n) begin
            comp_q       <= 128'd0;
            comp_valid_q <= 1'b0;
        end else begin
            if (valid_d) begin
                comp_q <= ~data_out_d;
            end else begin
                comp_q <= comp_q;
            end
            comp_valid_q <= valid_d;
        end
    end

    assign AES_data_out_complementary       = comp_q;
    assign AES_data_out_complementary_valid = comp_valid_q;
`endif

endmodule

// File: tb/tb_aes_top.sv
// -----------------------------------------------------------------------------
// tb_aes_top : scoreboard bench for aes_top. Expected ciphertexts come from a
// whole-block AES-128 model whose S-box is derived from the GF(2^8) inverse
// and the affine transform. A negedge monitor pops and compares the expected
// values whenever the DUT pulses valid.
// -----------------------------------------------------------------------------
module tb_aes_top;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [127:0] din = 128'd0;
    logic [127:0] kin = 128'd0;
    logic [127:0] dout;
    logic         dvalid;
`ifdef AES_COMPLEMENTARY_OUT_EN
    logic [127:0] dout_c;
    logic         dvalid_c;
`endif

    aes_top dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .AES_data_out       (dout),
        .AES_data_out_valid (dvalid)
`ifdef AES_COMPLEMENTARY_OUT_EN
        ,
        .AES_data_out_complementary       (dout_c),
        .AES_data_out_complementary_valid (dvalid_c)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ct;
        int           cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks     = 0;
    int         failures   = 0;
    int         cyc        = 0;
    int         valid_seen = 0;
    logic [7:0] sb [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // --------------------------------------------------------- reference model
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x   = v[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 8'h00 && gmul(x, y[7:0]) == 8'h01) inv = y[7:0];
            end
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = sb[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
                if (rnd < 10) begin
                    s[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[0][c] = a0; s[1][c] = a1; s[2][c] = a2; s[3][c] = a3;
                end
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    // ------------------------------------------------------------------ monitor
    always @(negedge clk) begin
        exp_t e;
        if (dvalid === 1'b1) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid got=%h expected=no_pulse", dout);
            end else begin
                e = exp_q.pop_front();
                chk("ciphertext", dout, e.ct);
                chk("latency_cycle", 128'(cyc), 128'(e.cyc));
`ifdef AES_COMPLEMENTARY_OUT_EN
                chk("comp_valid", {127'd0, dvalid_c}, 128'd1);
                chk("comp_data", dout_c, ~e.ct);
`endif
            end
        end
    end

    // ------------------------------------------------------------------ stimulus
    task automatic push_exp(input logic [127:0] k, input logic [127:0] p);
        exp_t e;
        e.ct  = ref_aes(k, p);
        e.cyc = cyc + 11;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Capture one block; optionally scramble inputs while the core is busy.
    task automatic run_block(input logic [127:0] k, input logic [127:0] p, input bit noise);
        logic [127:0] want;
        want = ref_aes(k, p);
        @(negedge clk);
        en = 1'b1; din = p; kin = k;
        push_exp(k, p);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (noise) begin
                en  = 1'($urandom_range(0, 1));
                din = {$urandom, $urandom, $urandom, $urandom};
                kin = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                en = 1'b0;
            end
        end
        @(negedge clk);
        en = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        chk("hold_output", dout, want);
    endtask

    initial begin
        logic [127:0] k, p;
        int           base;
        build_sbox();

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_data_out", dout, 128'd0);
        chk("reset_valid", {127'd0, dvalid}, 128'd0);
        rst = 1'b0;

        // Known-answer vectors
        run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 1'b0);
        chk("kat1_value", dout, 128'h3925841d02dc09fbdc118597196a0b32);
        run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 1'b0);
        chk("kat2_value", dout, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_block(128'd0, 128'd0, 1'b0);
        chk("kat3_value", dout, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        // Random blocks with scrambled inputs during BUSY
        for (int n = 0; n < 12; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            run_block(k, p, 1'b1);
        end

        // Back-to-back: en held high 51 cycles, data changes while busy
        k    = {$urandom, $urandom, $urandom, $urandom};
        p    = {$urandom, $urandom, $urandom, $urandom};
        base = valid_seen;
        for (int i = 0; i < 51; i++) begin
            @(negedge clk);
            en  = 1'b1;
            kin = k;
            if (i % 11 == 0) begin
                din = p;
                push_exp(k, p);
            end else begin
                din = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        @(negedge clk);
        en = 1'b0;
        wait_drain();
        chk("b2b_pulse_count", 128'(valid_seen - base), 128'd5);

        // Reset in the middle of an operation
        @(negedge clk);
        en = 1'b1; din = 128'h3243f6a8885a308d313198a2e0370734; kin = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        rst  = 1'b1;
        base = valid_seen;
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        chk("abort_no_valid", 128'(valid_seen - base), 128'd0);
        chk("abort_data_out", dout, 128'd0);
`ifdef AES_COMPLEMENTARY_OUT_EN
        chk("abort_comp_out", dout_c, 128'd0);
`endif

        // Capture on the first edge after reset release
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        push_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        wait_drain();
        chk("post_reset_value", dout, 128'h3925841d02dc09fbdc118597196a0b32);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
